arb_mux: RTL
============

# arb_mux

- Parametrised, registered successor to the combinational 8-way 16-bit multiplexer.
- Merges CHANNELS valid/ready input streams of WIDTH bits into one output stream.
- Arbitration is internal: round-robin, or fixed priority depending on build. Packets are held atomic via a `last` flag.
- Sits between multiple producers (e.g. memory-mapped peripherals) and a single consumer; one register stage of latency.

## Interface
- `WIDTH`, 16, data bits per channel.
- `CHANNELS`, 8, number of input channels; must be ≥ 2.
- `SEL_W` (localparam), clog2(CHANNELS), channel index width.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `in_data` in CHANNELS*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid` in CHANNELS: per-channel valid.
- `in_last` in CHANNELS: per-channel end-of-packet marker.
- `in_ready` out CHANNELS: per-channel ready; one-hot or zero.
- `out_data` out WIDTH: registered output data.
- `out_valid` out 1: output holds a beat.
- `out_last` out 1: registered copy of the accepted beat's `in_last`.
- `out_chan` out SEL_W: index of the channel that produced the output beat.
- `out_ready` in 1: consumer accepts the output beat.

## Operation
- Reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `out_chan`=0, state=IDLE, `ptr`=0. `in_ready` is forced to 0 while `reset` is high.
- `can_load` = !out_valid || out_ready.
- `in_ready[i]` = (i == grant) && `can_load` && state permits.
- A beat is accepted when `in_valid[grant] && in_ready[grant]`.

**States**
- IDLE:
  - grant = first valid channel, searching from `ptr` upward with wrap (CHANNELS-1 → 0).
  - If no channel is valid, no grant and all `in_ready`=0.
  - Accepted beat with last=0 → LOCKED(grant).
  - Accepted beat with last=1 → stay IDLE; `ptr` ← grant+1 mod CHANNELS.
- LOCKED(c):
  - grant = c regardless of other valids; other `in_ready` stay 0.
  - Accepted beat with last=1 → IDLE; `ptr` ← c+1 mod CHANNELS.
  - While `in_valid[c]`=0, the block waits; no other channel is served.

**Output register**
- On an accepted beat: load data, last and chan; `out_valid` ← 1.
- Otherwise, if `out_ready`: `out_valid` ← 0; data, last and chan hold their last values.
- Not loaded and no `out_ready`: all output registers hold.

**Wrap rules**
- `ptr` modulo arithmetic is on CHANNELS, not 2^SEL_W.
- A `ptr` increment from CHANNELS-1 yields 0, also for non-power-of-two CHANNELS.

## Timing
- Latency: an input beat accepted at edge N is visible on the outputs after edge N.
- Throughput: one beat per cycle while `out_ready` is held high.
- Simultaneous `out_ready` and a new acceptance: the output is replaced in the same edge with no bubble.
- `out_valid`=1 with `out_ready`=0: all `in_ready`=0, outputs stable.
- `reset` assertion clears registers immediately, without a clock edge.
  - Mid-packet reset drops the lock.
  - After release, the first edge arbitrates from `ptr`=0.
- Grant and `in_ready` are combinational from state, `ptr`, `in_valid` and `out_ready`. No combinational path from `in_data` to any output.

## Configuration
- `ARB_MUX_RR_EN` defined: round-robin; `ptr` updates as above.
- Not defined: fixed priority. Search always starts at channel 0 (lowest index wins), and `ptr` is constant 0.
- Packet lock applies in both builds.

## Structure
- Package `arb_mux_pkg`:
  - state encoding constants `ST_IDLE`, `ST_LOCKED`;
  - clog2 helper function.
- Sub-module `rr_arbiter`:
  - inputs: `req[CHANNELS]`, `ptr[SEL_W]`;
  - outputs: `gnt_idx[SEL_W]`, `gnt_any`;
  - combinational wrap-around priority search.
- Top holds the state, `ptr` and the output register.

## Test plan
All scenarios use WIDTH=16, CHANNELS=8.
1. Single beat:
   - Stimulus: ch3 valid, data 0xBEEF, last=1, `out_ready`=1.
   - Response: `in_ready`=8'b0000_1000 in that cycle. Next cycle `out_valid`=1, `out_data`=0xBEEF, `out_chan`=3, `out_last`=1.
2. Backpressure:
   - Stimulus: output holds 0x1234 with `out_ready`=0 for 5 cycles while ch0–ch7 are all valid.
   - Response: `in_ready`=0 every cycle; `out_data`=0x1234 stable. Raising `out_ready` resumes with no lost beat.
3. Arbitration order:
   - Stimulus: ch0, ch2 and ch5 continuously valid with single-beat packets, `out_ready`=1.
   - Response with `ARB_MUX_RR_EN`: `out_chan` = 0,2,5,0,2,5. Without it: 0,0,0,0,0,0.
4. Packet lock:
   - Stimulus: ch1 sends 0xA001, 0xA002, 0xA003 with last on the third; ch0 valid throughout.
   - Response: `out_chan` = 1,1,1, then 0 (RR build).
5. Wrap:
   - Stimulus: ch7 served (`ptr`←0 on wrap), then ch7 and ch0 both valid.
   - Response: ch0 wins next. Repeat with CHANNELS=5: `ptr` wraps 4→0.
6. Reset mid-packet:
   - Stimulus: `reset` pulse while LOCKED(4) after 2 beats.
   - Response: `out_valid`=0 before the next edge. After release, with ch0 and ch4 valid, ch0 is served first.

Source files
------------

// File: rtl/arb_mux_pkg.sv
// Shared definitions for the arb_mux stream merger: FSM state encoding,
// default geometry and a constant-evaluable clog2 used for index widths.
package arb_mux_pkg;

    // Packet-level arbitration state: free to pick a new channel, or held
    // on the channel whose packet is still in flight.
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_WIDTH    = 16;
    localparam int unsigned DEFAULT_CHANNELS = 8;

    // Index width for n channels; never below 1 so a 2-channel build still
    // gets a usable select bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Wrap-around priority search: returns the first requesting channel at or
// above ptr, falling back to the lowest requesting channel below it.
// Purely combinational.
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter  int unsigned CHANNELS = DEFAULT_CHANNELS,
    localparam int unsigned SEL_W    = clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic [SEL_W-1:0]    gnt_idx,
    output logic                gnt_any
);

    logic [SEL_W-1:0] hi_idx;
    logic             hi_any;
    logic [SEL_W-1:0] lo_idx;
    logic             lo_any;

    // Two ascending scans with constant indices: the masked scan covers
    // ptr..CHANNELS-1, the unmasked scan supplies the wrapped fallback.
    always_comb begin
        hi_idx = '0;
        hi_any = 1'b0;
        lo_idx = '0;
        lo_any = 1'b0;
        for (int unsigned j = 0; j < CHANNELS; j++) begin
            if (req[j] && !lo_any) begin
                lo_any = 1'b1;
                lo_idx = SEL_W'(j);
            end
            if (req[j] && !hi_any && (SEL_W'(j) >= ptr)) begin
                hi_any = 1'b1;
                hi_idx = SEL_W'(j);
            end
        end
    end

    // Prefer the channel found at or after ptr; otherwise wrap to the lowest.
    always_comb begin
        gnt_any = lo_any;
        gnt_idx = hi_any ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/arb_mux.sv
// arb_mux: merges CHANNELS valid/ready streams into one registered output
// stream with packet-atomic arbitration (a packet ends on in_last).
// Build option: define ARB_MUX_RR_EN for round-robin arbitration; without
// it the search always starts at channel 0 (fixed priority).
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter  int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter  int unsigned CHANNELS = DEFAULT_CHANNELS,
    localparam int unsigned SEL_W    = clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS-1:0]       in_last,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    output logic                      out_last,
    output logic [SEL_W-1:0]          out_chan,
    input  logic                      out_ready
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    state_t           state_q;
    state_t           state_d;
    logic [SEL_W-1:0] lock_q;
    logic [SEL_W-1:0] lock_d;
    logic [SEL_W-1:0] ptr_q;

    logic [SEL_W-1:0] arb_idx;
    logic             arb_any;
    logic [SEL_W-1:0] grant;
    logic             grant_any;

    logic             can_load;
    logic             accept;
    logic             sel_valid;
    logic             sel_last;
    logic [WIDTH-1:0] sel_data;

    rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_rr_arbiter (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    // A locked packet owns the grant even while its channel is idle.
    always_comb begin
        grant     = arb_idx;
        grant_any = arb_any;
        if (state_q == ST_LOCKED) begin
            grant     = lock_q;
            grant_any = 1'b1;
        end
    end

    // Select the granted channel's valid/last/data.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (grant == SEL_W'(i)) begin
                sel_valid = in_valid[i];
                sel_last  = in_last[i];
                sel_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign can_load = !out_valid || out_ready;
    assign accept   = grant_any && can_load && sel_valid;

    // One-hot ready to the granted channel; held low throughout reset.
    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (!reset && grant_any && can_load && (grant == SEL_W'(i))) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    // Next-state: lock on a non-final beat, release on the final beat.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (!sel_last) begin
                        state_d = ST_LOCKED;
                        lock_d  = grant;
                    end
                end
                ST_LOCKED: begin
                    if (sel_last) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and locked-channel registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
        end
    end

`ifdef ARB_MUX_RR_EN
    logic [SEL_W-1:0] ptr_d;

    // After a packet completes, the search restarts just past its channel,
    // wrapping at CHANNELS rather than at 2^SEL_W.
    always_comb begin
        ptr_d = ptr_q;
        if (accept && sel_last) begin
            ptr_d = (grant == LAST_CH) ? '0 : grant + 1'b1;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign ptr_q = '0;
`endif

    // Output stage: load on accept, drop valid when consumed, else hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_chan  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= sel_last;
            out_chan  <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
